ntt_bf_sched: RTL and testbench

NTT_BF_SCHED -- requirements
Module: ntt_bf_sched

---
 rtl/ntt_pkg.sv | 14 +
 rtl/bf_addr_delay.sv | 75 +++++++
 rtl/ntt_bf_sched.sv | 152 +++++++++++++++
 tb/tb_ntt_bf_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - NTT butterfly scheduler defaults and FSM state type.
package ntt_pkg;

  localparam int NTT_N        = 1024;
  localparam int NTT_LOG_N    = 10;
  localparam int NTT_PIPE_LAT = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } bf_state_e;

endpackage

// File: rtl/bf_addr_delay.sv
// rtl/bf_addr_delay.sv - LAT-cycle delay of {valid, addr_a, addr_b} feeding write-back.
module bf_addr_delay
  import ntt_pkg::*;
#(
  parameter int LAT = NTT_PIPE_LAT,
  parameter int AW  = NTT_LOG_N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr_a,
  input  logic [AW-1:0] in_addr_b,
  output logic          out_valid,
  output logic [AW-1:0] out_addr_a,
  output logic [AW-1:0] out_addr_b,
  output logic          in_flight
);

  logic [LAT-2:0]         v_q, v_d;
  logic [LAT-2:0][AW-1:0] a_q, a_d;
  logic [LAT-2:0][AW-1:0] b_q, b_d;
  logic                   ov_q, ov_d;
  logic [AW-1:0]          oa_q, oa_d;
  logic [AW-1:0]          ob_q, ob_d;

  // LAT-1 shift stages plus an output register that only loads on a valid,
  // so the write addresses hold their last written value between bursts.
  always_comb begin
    v_d    = v_q;
    a_d    = a_q;
    b_d    = b_q;
    v_d[0] = in_valid;
    a_d[0] = in_addr_a;
    b_d[0] = in_addr_b;
    for (int i = 1; i < LAT - 1; i++) begin
      v_d[i] = v_q[i-1];
      a_d[i] = a_q[i-1];
      b_d[i] = b_q[i-1];
    end
    ov_d = v_q[LAT-2];
    oa_d = v_q[LAT-2] ? a_q[LAT-2] : oa_q;
    ob_d = v_q[LAT-2] ? b_q[LAT-2] : ob_q;
    if (flush) begin
      v_d  = '0;
      ov_d = 1'b0;
      oa_d = oa_q;
      ob_d = ob_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      ov_q <= 1'b0;
      oa_q <= '0;
      ob_q <= '0;
    end else begin
      v_q  <= v_d;
      a_q  <= a_d;
      b_q  <= b_d;
      ov_q <= ov_d;
      oa_q <= oa_d;
      ob_q <= ob_d;
    end
  end

  assign out_valid  = ov_q;
  assign out_addr_a = oa_q;
  assign out_addr_b = ob_q;
  assign in_flight  = (|v_q) | ov_q;

endmodule

// File: rtl/ntt_bf_sched.sv
// rtl/ntt_bf_sched.sv - In-place radix-2 NTT butterfly address/strobe scheduler.
module ntt_bf_sched
  import ntt_pkg::*;
#(
  parameter int N        = NTT_N,
  parameter int LOG_N    = NTT_LOG_N,
  parameter int PIPE_LAT = NTT_PIPE_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-1:0] tw_idx,
  output logic             sr_clken,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b,
  output logic [LOG_N-1:0] stage
);

  localparam int               DW   = $clog2(PIPE_LAT);
  localparam logic [LOG_N-1:0] HALF = LOG_N'(N / 2);
  localparam logic [LOG_N-1:0] ONE  = LOG_N'(1);

  bf_state_e        state_q, state_d;
  logic [LOG_N-1:0] j_q, j_d;
  logic [LOG_N-1:0] k_q, k_d;
  logic [LOG_N-1:0] h_q, h_d;
  logic [LOG_N-1:0] addr_a_q, addr_a_d;
  logic [LOG_N-1:0] tw_q, tw_d;
  logic [LOG_N-1:0] stage_q, stage_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             done_q, done_d;
  logic             in_flight;

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    k_d      = k_q;
    h_d      = h_q;
    addr_a_d = addr_a_q;
    tw_d     = tw_q;
    stage_d  = stage_q;
    dcnt_d   = dcnt_q;
    done_d   = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d  = ISSUE;
            j_d      = '0;
            k_d      = '0;
            h_d      = HALF;
            addr_a_d = '0;
            tw_d     = ONE;
            stage_d  = '0;
          end
        end
        ISSUE: begin
          j_d = j_q + ONE;
          if (j_q == HALF - ONE) begin
            state_d = DRAIN;
            dcnt_d  = '0;
          end else if (k_q == h_q - ONE) begin
            // Group wrap: skip over the upper half-block to the next group base.
            k_d      = '0;
            addr_a_d = addr_a_q + h_q + ONE;
            tw_d     = tw_q + ONE;
          end else begin
            k_d      = k_q + ONE;
            addr_a_d = addr_a_q + ONE;
          end
        end
        DRAIN: begin
          dcnt_d = dcnt_q + DW'(1);
          if (dcnt_q == DW'(PIPE_LAT - 1)) begin
            if (stage_q == LOG_N'(LOG_N - 1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d  = ISSUE;
              stage_d  = stage_q + ONE;
              j_d      = '0;
              k_d      = '0;
              h_d      = h_q >> 1;
              addr_a_d = '0;
              tw_d     = ONE << (stage_q + ONE);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      j_q      <= '0;
      k_q      <= '0;
      h_q      <= '0;
      addr_a_q <= '0;
      tw_q     <= '0;
      stage_q  <= '0;
      dcnt_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      k_q      <= k_d;
      h_q      <= h_d;
      addr_a_q <= addr_a_d;
      tw_q     <= tw_d;
      stage_q  <= stage_d;
      dcnt_q   <= dcnt_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rd_en     = (state_q == ISSUE);
  assign rd_addr_a = addr_a_q;
  assign rd_addr_b = addr_a_q + h_q;
  assign tw_idx    = tw_q;
  assign stage     = stage_q;
  assign sr_clken  = rd_en | in_flight;

  bf_addr_delay #(
    .LAT (PIPE_LAT),
    .AW  (LOG_N)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .flush      (abort),
    .in_valid   (rd_en),
    .in_addr_a  (rd_addr_a),
    .in_addr_b  (rd_addr_b),
    .out_valid  (wr_en),
    .out_addr_a (wr_addr_a),
    .out_addr_b (wr_addr_b),
    .in_flight  (in_flight)
  );

endmodule

// File: tb/tb_ntt_bf_sched.sv
// tb/tb_ntt_bf_sched.sv - Bench for ntt_bf_sched against a cycle-level schedule model.
module tb_ntt_bf_sched;

  localparam int N     = 8;
  localparam int LOG_N = 3;
  localparam int PL    = 6;
  localparam int H     = N / 2;
  localparam int SLOT  = H + PL;
  localparam int TOTAL = 1 + LOG_N * SLOT;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [LOG_N-1:0] rd_addr_a;
  logic [LOG_N-1:0] rd_addr_b;
  logic [LOG_N-1:0] tw_idx;
  logic             sr_clken;
  logic             wr_en;
  logic [LOG_N-1:0] wr_addr_a;
  logic [LOG_N-1:0] wr_addr_b;
  logic [LOG_N-1:0] stage;

  ntt_bf_sched #(
    .N        (N),
    .LOG_N    (LOG_N),
    .PIPE_LAT (PL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_idx    (tw_idx),
    .sr_clken  (sr_clken),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .stage     (stage)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int a;
    int b;
  } wr_t;

  int  total = 0;
  int  bad   = 0;
  int  cur   = 0;
  int  t0    = 0;
  bit  run   = 1'b0;
  int  last_stage, last_ra, last_rb, last_wa, last_wb;
  wr_t wq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cur, obs, exp);
    end
  endtask

  task automatic model_reset();
    run = 1'b0;
    wq.delete();
    last_stage = 0;
    last_ra = 0;
    last_rb = 0;
    last_wa = 0;
    last_wb = 0;
  endtask

  // Expected outputs for the current cycle from the closed-form schedule.
  task automatic check_cycle();
    int  tc, s, off, h, g, k, a, b, tw;
    bit  in_run, rd, wr, flight;
    tc     = cur - t0;
    in_run = run && tc >= 1 && tc < TOTAL;
    rd     = 1'b0;
    tw     = 0;
    if (in_run) begin
      s          = (tc - 1) / SLOT;
      off        = (tc - 1) % SLOT;
      last_stage = s;
      if (off < H) begin
        rd = 1'b1;
        h  = N >> (s + 1);
        g  = off / h;
        k  = off % h;
        a  = 2 * g * h + k;
        b  = a + h;
        tw = (1 << s) + g;
        last_ra = a;
        last_rb = b;
        wq.push_back('{cur + PL, a, b});
      end
    end
    flight = (wq.size() > 0);
    wr     = 1'b0;
    if (flight) begin
      if (wq[0].due == cur) begin
        wr      = 1'b1;
        last_wa = wq[0].a;
        last_wb = wq[0].b;
        void'(wq.pop_front());
      end
    end
    chk("busy", 32'(busy), 32'(in_run));
    chk("done", 32'(done), 32'(run && tc == TOTAL));
    chk("rd_en", 32'(rd_en), 32'(rd));
    chk("rd_addr_a", 32'(rd_addr_a), last_ra);
    chk("rd_addr_b", 32'(rd_addr_b), last_rb);
    if (rd) chk("tw_idx", 32'(tw_idx), tw);
    chk("stage", 32'(stage), last_stage);
    chk("wr_en", 32'(wr_en), 32'(wr));
    chk("wr_addr_a", 32'(wr_addr_a), last_wa);
    chk("wr_addr_b", 32'(wr_addr_b), last_wb);
    chk("sr_clken", 32'(sr_clken), 32'(rd || flight));
  endtask

  task automatic cycle(input bit st, input bit ab);
    int tc;
    bit in_run;
    check_cycle();
    start  = st;
    abort  = ab;
    tc     = cur - t0;
    in_run = run && tc >= 1 && tc < TOTAL;
    if (run && tc >= TOTAL) run = 1'b0;
    if (in_run && ab) begin
      run = 1'b0;
      wq.delete();
    end else if (!in_run && st && !ab) begin
      run = 1'b1;
      t0  = cur;
    end
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic rst_pulse();
    check_cycle();
    start = 1'b0;
    abort = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_cycle();
    @(posedge clk);
    #1;
    cur++;
    check_cycle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    cur++;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      check_cycle();
      @(posedge clk);
      #1;
      cur++;
    end
    rst = 1'b0;
    cycle(0, 0);
    cycle(0, 0);

    // full transform, then back-to-back start in the done cycle
    cycle(1, 0);
    for (int i = 1; i < TOTAL; i++) cycle(0, 0);
    cycle(1, 0);
    for (int i = 1; i <= TOTAL + 2; i++) cycle(0, 0);

    // starts during a run are ignored
    cycle(1, 0);
    for (int i = 1; i <= TOTAL + 2; i++) cycle(i == 5 || i == 20, 0);

    // abort mid stage 1, then start+abort together in idle, then a clean run
    cycle(1, 0);
    for (int i = 1; i < 13; i++) cycle(0, 0);
    cycle(0, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0);
    cycle(1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0);
    cycle(1, 0);
    for (int i = 1; i <= TOTAL + 2; i++) cycle(0, 0);

    // reset pulse mid-transform, then a clean run
    cycle(1, 0);
    for (int i = 1; i < 8; i++) cycle(0, 0);
    rst_pulse();
    for (int i = 0; i < 10; i++) cycle(0, 0);
    cycle(1, 0);
    for (int i = 1; i <= TOTAL + 2; i++) cycle(0, 0);

    // random start/abort traffic
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
    end
    for (int i = 0; i <= TOTAL; i++) cycle(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
